// File: rtl/sram_bridge16_if.sv
// rtl/sram_bridge16_if.sv - core load/store port and external SRAM pins of the 16-bit data-memory bridge
interface sram_bridge16_if #(
   parameter int AW = 19
);
   logic          mreq;
   logic          mwr;
   logic          mbyte;
   logic [23:0]   adr;
   logic [31:0]   outbus;
   logic [31:0]   inbus;
   logic          stallX;
   logic [AW-1:0] sram_a;
   logic [15:0]   sram_dq_o;
   logic [15:0]   sram_dq_i;
   logic          sram_dq_oe;
   logic          sram_ce_n;
   logic          sram_oe_n;
   logic          sram_we_n;
   logic          sram_lb_n;
   logic          sram_ub_n;

   // master: the core plus the SRAM device; slave: the bridge itself
   modport master (
      output mreq, mwr, mbyte, adr, outbus, sram_dq_i,
      input  inbus, stallX, sram_a, sram_dq_o, sram_dq_oe,
             sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n
   );

   modport slave (
      input  mreq, mwr, mbyte, adr, outbus, sram_dq_i,
      output inbus, stallX, sram_a, sram_dq_o, sram_dq_oe,
             sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n
   );
endinterface

// File: rtl/sram_bridge16.sv
// rtl/sram_bridge16.sv - splits 32-bit word/byte core accesses into 16-bit async SRAM phases
module sram_bridge16 #(
   parameter int AW   = 19,
   parameter int WAIT = 1
) (
   input  logic           clk,
   input  logic           rst,
   sram_bridge16_if.slave bus
);
   localparam int WCW = (WAIT > 0) ? $clog2(WAIT + 1) : 1;

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      STB,
      HOLD,
      DONE
   } state_t;

   state_t         state_q, state_d;
   logic           ph_q, ph_d;
   logic [WCW-1:0] wc_q, wc_d;
   logic           done_q, done_d;
   logic [31:0]    inbus_q, inbus_d;
   logic           mwr_q, mwr_d;
   logic           mbyte_q, mbyte_d;
   logic [AW:0]    adr_q, adr_d;
   logic           hit;
   logic           active;

   assign hit = bus.mreq & (bus.adr[23:AW+1] == '0);

   // stallX must not depend on the FSM's next state, only on the request and done_q
   assign bus.stallX = hit & ~done_q & ~rst;
   assign bus.inbus  = (bus.mreq & ~hit) ? 32'h0 : inbus_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         ph_q    <= 1'b0;
         wc_q    <= '0;
         done_q  <= 1'b0;
         inbus_q <= 32'h0;
         mwr_q   <= 1'b0;
         mbyte_q <= 1'b0;
         adr_q   <= '0;
      end else begin
         state_q <= state_d;
         ph_q    <= ph_d;
         wc_q    <= wc_d;
         done_q  <= done_d;
         inbus_q <= inbus_d;
         mwr_q   <= mwr_d;
         mbyte_q <= mbyte_d;
         adr_q   <= adr_d;
      end
   end

   // Request qualifiers are latched so an early mreq drop still finishes cleanly
   always_comb begin
      state_d = state_q;
      ph_d    = ph_q;
      wc_d    = wc_q;
      done_d  = done_q;
      inbus_d = inbus_q;
      mwr_d   = mwr_q;
      mbyte_d = mbyte_q;
      adr_d   = adr_q;

      case (state_q)
         IDLE: begin
            done_d = 1'b0;
            if (hit) begin
               state_d = SETUP;
               ph_d    = bus.mbyte ? bus.adr[1] : 1'b0;
               mwr_d   = bus.mwr;
               mbyte_d = bus.mbyte;
               adr_d   = bus.adr[AW:0];
            end
         end
         SETUP: begin
            state_d = STB;
            wc_d    = '0;
         end
         STB: begin
            if (wc_q == WCW'(WAIT)) begin
               state_d = HOLD;
               if (!mwr_q) begin
                  if (ph_q) begin
                     inbus_d[31:16] = bus.sram_dq_i;
                     if (mbyte_q) inbus_d[15:0] = 16'h0;
                  end else begin
                     inbus_d[15:0] = bus.sram_dq_i;
                     if (mbyte_q) inbus_d[31:16] = 16'h0;
                  end
               end
            end else begin
               wc_d = wc_q + 1'b1;
            end
         end
         HOLD: begin
            if (!mbyte_q && !ph_q) begin
               ph_d    = 1'b1;
               state_d = SETUP;
            end else if (bus.mreq) begin
               done_d  = 1'b1;
               state_d = DONE;
            end else begin
               state_d = IDLE;
            end
         end
         DONE: begin
            if (!bus.mreq) begin
               done_d  = 1'b0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Pin drive is decoded from registered state, so reset releases every strobe at once
   always_comb begin
      active         = (state_q == SETUP) || (state_q == STB) || (state_q == HOLD);
      bus.sram_ce_n  = ~active;
      bus.sram_a     = '0;
      bus.sram_dq_o  = 16'h0;
      bus.sram_dq_oe = 1'b0;
      bus.sram_oe_n  = 1'b1;
      bus.sram_we_n  = 1'b1;
      bus.sram_lb_n  = 1'b1;
      bus.sram_ub_n  = 1'b1;
      if (active) begin
         bus.sram_a    = {adr_q[AW:2], ph_q};
         bus.sram_lb_n = mbyte_q & adr_q[0];
         bus.sram_ub_n = mbyte_q & ~adr_q[0];
         if (mwr_q) begin
            bus.sram_dq_oe = 1'b1;
            bus.sram_dq_o  = ph_q ? bus.outbus[31:16] : bus.outbus[15:0];
         end
         if (state_q == STB) begin
            bus.sram_oe_n = mwr_q;
            bus.sram_we_n = ~mwr_q;
         end
      end
   end
endmodule

// File: tb/tb_sram_bridge16.sv
// tb/tb_sram_bridge16.sv - runs WAIT=1 and WAIT=0 bridges in lockstep against a byte-level memory model
module tb_sram_bridge16;
   localparam int AW = 19;

   logic        clk = 1'b0;
   logic        rst;
   logic        mreq, mwr, mbyte;
   logic [23:0] adr;
   logic [31:0] outbus;

   always #5 clk = ~clk;

   sram_bridge16_if #(.AW(AW)) b0 ();
   sram_bridge16_if #(.AW(AW)) b1 ();

   assign b0.mreq = mreq;  assign b0.mwr = mwr;  assign b0.mbyte = mbyte;
   assign b0.adr  = adr;   assign b0.outbus = outbus;
   assign b1.mreq = mreq;  assign b1.mwr = mwr;  assign b1.mbyte = mbyte;
   assign b1.adr  = adr;   assign b1.outbus = outbus;

   sram_bridge16 #(.AW(AW), .WAIT(1)) u_w1 (.clk(clk), .rst(rst), .bus(b0));
   sram_bridge16 #(.AW(AW), .WAIT(0)) u_w0 (.clk(clk), .rst(rst), .bus(b1));

   bit [15:0] mem0 [0:(1<<AW)-1];
   bit [15:0] mem1 [0:(1<<AW)-1];

   assign b0.sram_dq_i = (!b0.sram_ce_n && !b0.sram_oe_n) ? mem0[b0.sram_a] : 16'h0;
   assign b1.sram_dq_i = (!b1.sram_ce_n && !b1.sram_oe_n) ? mem1[b1.sram_a] : 16'h0;

   always @(negedge clk) begin
      if (!b0.sram_ce_n && !b0.sram_we_n) begin
         if (!b0.sram_lb_n) mem0[b0.sram_a][7:0]  <= b0.sram_dq_o[7:0];
         if (!b0.sram_ub_n) mem0[b0.sram_a][15:8] <= b0.sram_dq_o[15:8];
      end
      if (!b1.sram_ce_n && !b1.sram_we_n) begin
         if (!b1.sram_lb_n) mem1[b1.sram_a][7:0]  <= b1.sram_dq_o[7:0];
         if (!b1.sram_ub_n) mem1[b1.sram_a][15:8] <= b1.sram_dq_o[15:8];
      end
   end

   logic [1:0]    stall, we_n, oe_n, ce_n, lb_n, ub_n, oe;
   logic [31:0]   inb [2];
   logic [AW-1:0] sa  [2];
   logic [15:0]   dqo [2];

   assign stall = {b1.stallX, b0.stallX};
   assign we_n  = {b1.sram_we_n, b0.sram_we_n};
   assign oe_n  = {b1.sram_oe_n, b0.sram_oe_n};
   assign ce_n  = {b1.sram_ce_n, b0.sram_ce_n};
   assign lb_n  = {b1.sram_lb_n, b0.sram_lb_n};
   assign ub_n  = {b1.sram_ub_n, b0.sram_ub_n};
   assign oe    = {b1.sram_dq_oe, b0.sram_dq_oe};
   assign inb[0] = b0.inbus;     assign inb[1] = b1.inbus;
   assign sa[0]  = b0.sram_a;    assign sa[1]  = b1.sram_a;
   assign dqo[0] = b0.sram_dq_o; assign dqo[1] = b1.sram_dq_o;

   bit [7:0] ref_mem [int];
   int total = 0;
   int bad   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic bit [7:0] ref_rd(input int a);
      return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
   endfunction

   // One core access on both bridges; mreq stays up until the slower one has retired
   task automatic access(input logic wr, input logic byt, input logic [23:0] a, input logic [31:0] d);
      int          k, w, ab;
      int          cnt [2], wl [2], ol [2], errs [2];
      bit          fin [2];
      logic [31:0] got [2];
      logic [31:0] exp_rd;
      logic [15:0] hw;
      k = byt ? 1 : 2;
      for (int i = 0; i < 2; i++) begin
         cnt[i] = 0; wl[i] = 0; ol[i] = 0; errs[i] = 0; fin[i] = 0; got[i] = 32'h0;
      end
      @(posedge clk); #1;
      mreq = 1'b1; mwr = wr; mbyte = byt; adr = a; outbus = d;
      for (int c = 0; c < 40 && !(fin[0] && fin[1]); c++) begin
         @(negedge clk);
         for (int i = 0; i < 2; i++) begin
            if (!fin[i]) begin
               if (stall[i]) cnt[i]++;
               else begin fin[i] = 1; got[i] = inb[i]; end
               if (!we_n[i]) begin
                  wl[i]++;
                  if (!oe[i] || dqo[i] !== (sa[i][0] ? d[31:16] : d[15:0])) errs[i]++;
               end
               if (!oe_n[i]) ol[i]++;
               if (!ce_n[i]) begin
                  if (sa[i][AW-1:1] !== a[AW:2] || (byt && sa[i][0] !== a[1])) errs[i]++;
                  if (lb_n[i] !== (byt & a[0]) || ub_n[i] !== (byt & ~a[0])) errs[i]++;
               end
            end
         end
      end
      ab = int'(a) & ~3;
      if (byt) begin
         hw = {ref_rd((int'(a) & ~1) | 1), ref_rd(int'(a) & ~1)};
         exp_rd = a[1] ? {hw, 16'h0} : {16'h0, hw};
      end else begin
         exp_rd = {ref_rd(ab + 3), ref_rd(ab + 2), ref_rd(ab + 1), ref_rd(ab)};
      end
      for (int i = 0; i < 2; i++) begin
         w = (i == 0) ? 1 : 0;
         check($sformatf("retired[%0d] a=%h", i, a), 32'(fin[i]), 32'd1);
         check($sformatf("stall_cycles[%0d] a=%h", i, a), cnt[i], 1 + k * (w + 3));
         check($sformatf("we_low[%0d] a=%h", i, a), wl[i], wr ? k * (w + 1) : 0);
         check($sformatf("oe_low[%0d] a=%h", i, a), ol[i], wr ? 0 : k * (w + 1));
         check($sformatf("pins[%0d] a=%h", i, a), errs[i], 0);
         if (!wr) check($sformatf("rdata[%0d] a=%h", i, a), got[i], exp_rd);
      end
      if (wr) begin
         if (byt) ref_mem[int'(a)] = d[8*a[1:0] +: 8];
         else for (int j = 0; j < 4; j++) ref_mem[ab + j] = d[8*j +: 8];
      end
      @(posedge clk); #1;
      mreq = 1'b0;
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [23:0] a;
      logic [31:0] d;
      logic        wr, byt;
      rst = 1'b1; mreq = 1'b0; mwr = 1'b0; mbyte = 1'b0; adr = 24'h0; outbus = 32'h0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_ce_n", ce_n, 2'b11);
      check("rst_we_oe_n", {we_n, oe_n}, 4'hF);
      check("rst_lanes_n", {lb_n, ub_n}, 4'hF);
      check("rst_dq_oe", oe, 2'b00);
      check("rst_sram_a", {sa[1], sa[0]}, 0);
      check("rst_dq_o", {dqo[1], dqo[0]}, 0);
      check("rst_inbus0", inb[0], 32'h0);
      check("rst_inbus1", inb[1], 32'h0);
      mreq = 1'b1; #1;
      check("rst_stall_forced", stall, 2'b00);
      mreq = 1'b0;
      @(posedge clk); #1 rst = 1'b0;

      access(1'b1, 1'b0, 24'h000104, 32'hDEADBEEF);
      check("mem0_82", mem0[19'h82], 16'hBEEF);
      check("mem0_83", mem0[19'h83], 16'hDEAD);
      check("mem1_83", mem1[19'h83], 16'hDEAD);
      access(1'b0, 1'b0, 24'h000104, 32'h0);
      access(1'b1, 1'b1, 24'h000107, 32'h5A5A5A5A);
      check("mem0_83_byte", mem0[19'h83], 16'h5AAD);
      check("mem1_83_byte", mem1[19'h83], 16'h5AAD);
      access(1'b0, 1'b1, 24'h000107, 32'h0);

      @(posedge clk); #1;
      mreq = 1'b1; mwr = 1'b0; mbyte = 1'b0; adr = 24'hFFFFC0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         check("miss_stall", stall, 2'b00);
         check("miss_ce_n", ce_n, 2'b11);
         check("miss_inbus0", inb[0], 32'h0);
         check("miss_inbus1", inb[1], 32'h0);
      end
      @(posedge clk); #1 mreq = 1'b0;

      @(posedge clk); #1;
      mreq = 1'b1; mwr = 1'b1; mbyte = 1'b0; adr = 24'h000200; outbus = 32'h12345678;
      repeat (6) @(posedge clk);
      #1;
      check("prerst_we_low", we_n[0], 1'b0);
      #1 rst = 1'b1;
      #1;
      check("midrst_we_n", we_n, 2'b11);
      check("midrst_ce_n", ce_n, 2'b11);
      check("midrst_dq_oe", oe, 2'b00);
      check("midrst_stall", stall, 2'b00);
      mreq = 1'b0;
      @(posedge clk); #1 rst = 1'b0;
      access(1'b0, 1'b1, 24'h000104, 32'h0);
      access(1'b1, 1'b0, 24'h000200, 32'h0BADF00D);
      access(1'b0, 1'b0, 24'h000200, 32'h0);

      @(posedge clk); #1;
      mreq = 1'b1; mwr = 1'b0; mbyte = 1'b0; adr = 24'h000300;
      repeat (3) @(posedge clk);
      #1 mreq = 1'b0;
      repeat (12) @(posedge clk);
      #1;
      check("early_drop_ce_n", ce_n, 2'b11);
      check("early_drop_stall", stall, 2'b00);
      access(1'b0, 1'b0, 24'h000300, 32'h0);

      access(1'b0, 1'b0, 24'h000104, 32'h0);
      access(1'b0, 1'b0, 24'h000200, 32'h0);

      for (int n = 0; n < 80; n++) begin
         wr  = 1'($urandom_range(0, 1));
         byt = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 7) == 0) a = 24'h100000 - 24'($urandom_range(1, 16));
         else a = 24'($urandom_range(0, 1023));
         d = $urandom;
         if (byt) d = {4{d[7:0]}};
         access(wr, byt, a, d);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
